if_id_2023211063: RTL

- Pipeline register between the fetch unit and the decode stage of the tinyriscv core.
- Latches the fetched instruction, its address and the static branch prediction (taken flag and target).
- Stalls under decode hold and inserts NOP bubbles on flush or invalid fetch.
- Owns a one-entry skid buffer and a ready signal back to pc_reg, so an instruction fetched in a hold cycle is never lost.

---
 rtl/if_id_2023211063_pkg.sv | 30 +++
 rtl/if_id_2023211063_if.sv | 37 +++
 rtl/skid_buf_2023211063.sv | 65 ++++++
 rtl/if_id_2023211063.sv | 112 +++++++++++
 4 files changed

// File: rtl/if_id_2023211063_pkg.sv
// Shared types and constants for the IF/ID pipeline register of the tinyriscv core.
// Field widths follow the core's instruction/address bus definitions.
package if_id_2023211063_pkg;

  localparam int          INST_W     = 32;
  localparam int          ADDR_W     = 32;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] INST_NOP   = 32'h0000_0001;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
    logic              prdt_taken;
    logic [ADDR_W-1:0] prdt_addr;
  } fetch_t;

  localparam fetch_t FETCH_ZERO = '{inst: ZERO_WORD, addr: ZERO_WORD,
                                    prdt_taken: 1'b0, prdt_addr: ZERO_WORD};

  function automatic fetch_t bubble_of(input logic [INST_W-1:0] nop_inst);
    return '{inst: nop_inst, addr: ZERO_WORD, prdt_taken: 1'b0, prdt_addr: ZERO_WORD};
  endfunction

endpackage

// File: rtl/if_id_2023211063_if.sv
// Fetch-to-decode bundle: fetch word and ready on one side, id slot and counters on the other.
interface if_id_2023211063_if #(
  parameter int PERF_W = 16
);
  import if_id_2023211063_pkg::*;

  logic [INST_W-1:0] if_inst_i;
  logic [ADDR_W-1:0] if_inst_addr_i;
  logic              if_prdt_taken_i;
  logic [ADDR_W-1:0] if_prdt_addr_i;
  logic              if_valid_i;
  logic              if_ready_o;
  logic              hold_i;
  logic              flush_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              prdt_taken_o;
  logic [ADDR_W-1:0] prdt_addr_o;
  logic              valid_o;
  logic [PERF_W-1:0] flush_cnt_o;
  logic [PERF_W-1:0] bubble_cnt_o;

  modport master (
    output if_inst_i, if_inst_addr_i, if_prdt_taken_i, if_prdt_addr_i, if_valid_i,
    output hold_i, flush_i,
    input  if_ready_o, inst_o, inst_addr_o, prdt_taken_o, prdt_addr_o, valid_o,
    input  flush_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  if_inst_i, if_inst_addr_i, if_prdt_taken_i, if_prdt_addr_i, if_valid_i,
    input  hold_i, flush_i,
    output if_ready_o, inst_o, inst_addr_o, prdt_taken_o, prdt_addr_o, valid_o,
    output flush_cnt_o, bubble_cnt_o
  );

endinterface

// File: rtl/skid_buf_2023211063.sv
// One-entry skid register holding a fetch word captured while decode is stalled.
// Clear wins over load; the full flag is the only control state of the IF/ID stage.
module skid_buf_2023211063
  import if_id_2023211063_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_clear,
  input  fetch_t i_data,
  output fetch_t o_data,
  output logic   o_full
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  fetch_t      r_data;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SKID_EMPTY: begin
        if (i_clear) begin
          w_state_nxt = SKID_EMPTY;
        end else if (i_load) begin
          w_state_nxt = SKID_FULL;
        end else begin
          w_state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (i_clear) begin
          w_state_nxt = SKID_EMPTY;
        end else begin
          w_state_nxt = SKID_FULL;
        end
      end
      default: w_state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_data <= FETCH_ZERO;
    end else if (i_clear) begin
      r_data <= FETCH_ZERO;
    end else if (i_load) begin
      r_data <= i_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign o_data = r_data;
  assign o_full = (r_state == SKID_FULL);

endmodule

// File: rtl/if_id_2023211063.sv
// IF/ID pipeline register: latches the fetch word and prediction, stalls on hold,
// inserts NOP bubbles on flush or empty fetch, and parks one in-flight fetch in a skid.
module if_id_2023211063
  import if_id_2023211063_pkg::*;
#(
  parameter int          PERF_W   = 16,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic              clk,
  input  logic              rst,
  if_id_2023211063_if.slave bus
);

  localparam logic [PERF_W-1:0] CNT_MAX = {PERF_W{1'b1}};
  localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] CNT_ZERO = {PERF_W{1'b0}};

  fetch_t            w_if_word;
  fetch_t            w_skid_word;
  fetch_t            w_out_nxt;
  fetch_t            r_out;
  logic              w_valid_nxt;
  logic              r_valid;
  logic              w_skid_full;
  logic              w_accept;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_bubble;
  logic [PERF_W-1:0] r_flush_cnt;
  logic [PERF_W-1:0] r_bubble_cnt;

  assign w_if_word = '{inst: bus.if_inst_i, addr: bus.if_inst_addr_i,
                       prdt_taken: bus.if_prdt_taken_i, prdt_addr: bus.if_prdt_addr_i};

  // Ready depends only on the skid flag so pc_reg never sees a path from hold/flush.
  assign bus.if_ready_o = ~w_skid_full;
  assign w_accept       = bus.if_valid_i & ~w_skid_full;
  assign w_skid_load    = bus.hold_i & ~bus.flush_i & w_accept;
  assign w_skid_clear   = bus.flush_i | (~bus.hold_i & w_skid_full);

  skid_buf_2023211063 u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_if_word),
    .o_data  (w_skid_word),
    .o_full  (w_skid_full)
  );

  // Next id-slot contents: flush beats hold, and a full skid drains before new fetches.
  always_comb begin
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;
    w_bubble    = 1'b0;
    if (bus.flush_i) begin
      w_out_nxt   = bubble_of(NOP_INST);
      w_valid_nxt = 1'b0;
    end else if (bus.hold_i) begin
      w_out_nxt   = r_out;
      w_valid_nxt = r_valid;
    end else if (w_skid_full) begin
      w_out_nxt   = w_skid_word;
      w_valid_nxt = 1'b1;
    end else if (w_accept) begin
      w_out_nxt   = w_if_word;
      w_valid_nxt = 1'b1;
    end else begin
      w_out_nxt   = bubble_of(NOP_INST);
      w_valid_nxt = 1'b0;
      w_bubble    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_out   <= bubble_of(NOP_INST);
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_flush_cnt  <= CNT_ZERO;
      r_bubble_cnt <= CNT_ZERO;
    end else begin
      if (bus.flush_i && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
      if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign bus.inst_o       = r_out.inst;
  assign bus.inst_addr_o  = r_out.addr;
  assign bus.prdt_taken_o = r_out.prdt_taken;
  assign bus.prdt_addr_o  = r_out.prdt_addr;
  assign bus.valid_o      = r_valid;
  assign bus.flush_cnt_o  = r_flush_cnt;
  assign bus.bubble_cnt_o = r_bubble_cnt;

endmodule
